// File: rtl/button_event_master.sv
// Avalon-MM master that polls a single-bit button PIO's edge-capture register,
// clears captured edges and posts the sampled button level on a valid/ready stream.
module button_event_master #(
  parameter int POLL_CYCLES = 50000,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_chipselect,
  output logic              avm_write_n,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  output logic              event_valid,
  input  logic              event_ready,
  output logic              event_level,
  output logic [CNT_W-1:0]  event_count,
  output logic              overrun,
  input  logic              overrun_clr
);

  localparam int PCNT_W = $clog2(POLL_CYCLES);
  localparam logic [PCNT_W-1:0] RELOAD = PCNT_W'(POLL_CYCLES - 1);
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_EDGE,
    CHK_EDGE,
    CLR,
    RD_DATA,
    CAP
  } state_t;

  state_t            state, state_next;
  logic [PCNT_W-1:0] poll_cnt, poll_cnt_next;
  logic [1:0]        addr, addr_next;
  logic              cap, accept;

  // Only bit 0 of the PIO carries information.
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata[31:1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      poll_cnt <= RELOAD;
      addr     <= ADDR_DATA;
    end else begin
      state    <= state_next;
      poll_cnt <= poll_cnt_next;
      addr     <= addr_next;
    end
  end

  always_comb begin
    state_next    = state;
    poll_cnt_next = poll_cnt;
    addr_next     = addr;
    case (state)
      IDLE: begin
        if (!enable) begin
          poll_cnt_next = RELOAD;
        end else if (poll_cnt == '0) begin
          state_next = RD_EDGE;
          addr_next  = ADDR_EDGE;
        end else begin
          poll_cnt_next = poll_cnt - 1'b1;
        end
      end
      RD_EDGE: state_next = CHK_EDGE;
      CHK_EDGE: begin
        if (avm_readdata[0]) begin
          state_next = CLR;
        end else begin
          state_next    = IDLE;
          poll_cnt_next = RELOAD;
        end
      end
      CLR: begin
        state_next = RD_DATA;
        addr_next  = ADDR_DATA;
      end
      RD_DATA: state_next = CAP;
      CAP: begin
        state_next    = IDLE;
        poll_cnt_next = RELOAD;
      end
      default: begin
        state_next    = IDLE;
        poll_cnt_next = RELOAD;
      end
    endcase
  end

  // Bus strobes decode straight from the state so reset idles the bus immediately.
  assign avm_chipselect = (state == RD_EDGE) || (state == CLR) || (state == RD_DATA);
  assign avm_write_n    = (state != CLR);
  assign avm_address    = addr;
  assign avm_writedata  = '0;

  assign cap    = (state == CAP);
  assign accept = event_valid & event_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_valid <= 1'b0;
      event_level <= 1'b0;
      event_count <= '0;
      overrun     <= 1'b0;
    end else begin
      if (cap) begin
        event_count <= event_count + 1'b1;
        if (!event_valid || accept) begin
          event_valid <= 1'b1;
          event_level <= avm_readdata[0];
        end
      end else if (accept) begin
        event_valid <= 1'b0;
      end
      // A new edge against a still-pending event beats a simultaneous clear.
      if (cap && event_valid && !event_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_event_master.sv
// Self-checking bench for button_event_master: a behavioural PIO slave plus an
// event scoreboard driven by observed data reads.
module tb_button_event_master;

  localparam int P  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b0;
  logic          event_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [1:0]    avm_address;
  logic          avm_chipselect, avm_write_n;
  logic [31:0]   avm_writedata;
  logic [31:0]   avm_readdata;
  logic          event_valid, event_level, overrun;
  logic [CW-1:0] event_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  button_event_master #(.POLL_CYCLES(P), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata),
    .event_valid(event_valid), .event_ready(event_ready),
    .event_level(event_level), .event_count(event_count),
    .overrun(overrun), .overrun_clr(overrun_clr)
  );

  // PIO slave: edge-capture bit at word 3 (any write clears), button at word 0.
  logic        edge_bit = 1'b0;
  logic        button = 1'b0;
  logic        inject = 1'b0;
  logic [31:0] rd_q = '0;
  assign avm_readdata = rd_q;

  always @(posedge clk) begin
    rd_q <= '0;
    if (avm_chipselect && avm_write_n) begin
      if (avm_address == 2'd3) rd_q <= {31'b0, edge_bit};
      else if (avm_address == 2'd0) rd_q <= {31'b0, button};
    end
    if (avm_chipselect && !avm_write_n && avm_address == 2'd3) edge_bit <= 1'b0;
    if (inject) edge_bit <= 1'b1;
  end

  // Event scoreboard: every button read produces one event one cycle later.
  logic          m_valid, m_level, m_ovr, cap_pend, cap_lvl;
  logic [CW-1:0] m_count;
  wire           m_accept = m_valid & event_ready;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0; m_level <= 1'b0; m_ovr <= 1'b0;
      m_count <= '0; cap_pend <= 1'b0; cap_lvl <= 1'b0;
    end else begin
      cap_pend <= avm_chipselect && avm_write_n && (avm_address == 2'd0);
      cap_lvl  <= button;
      if (cap_pend) begin
        m_count <= m_count + 1'b1;
        if (!m_valid || m_accept) begin
          m_valid <= 1'b1;
          m_level <= cap_lvl;
        end
      end else if (m_accept) begin
        m_valid <= 1'b0;
      end
      if (cap_pend && m_valid && !m_accept) m_ovr <= 1'b1;
      else if (overrun_clr) m_ovr <= 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic       obs_cs [6];
  logic       obs_wn [6];
  logic [1:0] obs_addr [6];
  logic [31:0] obs_wd [6];

  function automatic logic is_rd3();
    return avm_chipselect && avm_write_n && (avm_address == 2'd3);
  endfunction

  // Cycles from now until an edge-register read is on the bus; -1 on timeout.
  task automatic wait_rd3(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!is_rd3() && n < 200);
    if (!is_rd3()) n = -1;
  endtask

  // Capture one edge with the given button level and record the 6 cycles RD3..post.
  task automatic edge_poll(input logic lvl, input bit ready_cap, input bit drop_en);
    int n;
    button = lvl;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    wait_rd3(n);
    tests++;
    if (n < 0) begin
      fails++;
      $display("FAIL edge_poll_timeout: got no RD3 within 200 cycles, required one");
    end
    for (int i = 0; i < 5; i++) begin
      obs_cs[i] = avm_chipselect; obs_wn[i] = avm_write_n;
      obs_addr[i] = avm_address; obs_wd[i] = avm_writedata;
      if (i == 2 && drop_en) enable = 1'b0;
      if (i == 4 && ready_cap) event_ready = 1'b1;
      @(negedge clk);
    end
    obs_cs[5] = avm_chipselect; obs_wn[5] = avm_write_n;
    obs_addr[5] = avm_address; obs_wd[5] = avm_writedata;
    if (ready_cap) event_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({avm_chipselect, avm_write_n, avm_address, avm_writedata, event_valid,
         event_level, event_count, overrun} !== {1'b0, 1'b1, 2'd0, 32'd0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL reset_values: cs=%b wn=%b a=%0d wd=%h v=%b l=%b cnt=%0d ovr=%b, required 0 1 0 0 0 0 0 0",
               avm_chipselect, avm_write_n, avm_address, avm_writedata, event_valid, event_level, event_count, overrun);
    end
    reset_n = 1'b1;
    $display("[TB] reset checked");
  endtask

  task automatic test_poll_period();
    int n;
    enable = 1'b1;
    wait_rd3(n);
    tests++;
    if (n !== P) begin
      fails++;
      $display("FAIL first_poll: got %0d cycles, required %0d", n, P);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (avm_chipselect !== 1'b0 || avm_address !== 2'd3) begin
        fails++;
        $display("FAIL chk_edge_bus: cs=%b a=%0d, required cs=0 a=3", avm_chipselect, avm_address);
      end
      wait_rd3(n);
      n = n + 1;
      tests++;
      if (n !== P + 2) begin
        fails++;
        $display("FAIL poll_period: got %0d cycles, required %0d", n, P + 2);
      end
    end
    tests++;
    if (event_valid !== 1'b0 || event_count !== '0) begin
      fails++;
      $display("FAIL idle_no_event: v=%b cnt=%0d, required 0 0", event_valid, event_count);
    end
    $display("[TB] poll period checked");
  endtask

  task automatic test_edge_event();
    logic [3:0] seq_ok;
    edge_poll(1'b1, 1'b0, 1'b0);
    seq_ok[0] = obs_cs[0] && obs_wn[0] && obs_addr[0] == 2'd3;
    seq_ok[1] = !obs_cs[1] && obs_addr[1] == 2'd3;
    seq_ok[2] = obs_cs[2] && !obs_wn[2] && obs_addr[2] == 2'd3 && obs_wd[2] == 32'd0;
    seq_ok[3] = obs_cs[3] && obs_wn[3] && obs_addr[3] == 2'd0 && !obs_cs[4];
    tests++;
    if (seq_ok !== 4'hF) begin
      fails++;
      $display("FAIL edge_bus_seq: step ok flags=%b, required 1111", seq_ok);
    end
    tests++;
    if ({event_valid, event_level, event_count} !== {1'b1, 1'b1, CW'(1)}) begin
      fails++;
      $display("FAIL first_event: v=%b l=%b cnt=%0d, required 1 1 1", event_valid, event_level, event_count);
    end
    $display("[TB] edge event checked");
  endtask

  task automatic test_overrun();
    edge_poll(1'b0, 1'b0, 1'b0);
    tests++;
    if ({event_valid, event_level, event_count, overrun} !== {1'b1, 1'b1, CW'(2), 1'b1}) begin
      fails++;
      $display("FAIL overrun_set: v=%b l=%b cnt=%0d ovr=%b, required 1 1 2 1",
               event_valid, event_level, event_count, overrun);
    end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    tests++;
    if (event_valid !== 1'b0) begin
      fails++;
      $display("FAIL accept_drop: v=%b, required 0", event_valid);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_clr: ovr=%b, required 0", overrun);
    end
    $display("[TB] overrun checked");
  endtask

  task automatic test_back_to_back();
    edge_poll(1'b1, 1'b0, 1'b0);
    edge_poll(1'b0, 1'b1, 1'b0);
    tests++;
    if ({event_valid, event_level, event_count, overrun} !== {1'b1, 1'b0, CW'(4), 1'b0}) begin
      fails++;
      $display("FAIL same_cycle_accept: v=%b l=%b cnt=%0d ovr=%b, required 1 0 4 0",
               event_valid, event_level, event_count, overrun);
    end
    event_ready = 1'b1;
    @(negedge clk);
    event_ready = 1'b0;
    $display("[TB] back-to-back accept checked");
  endtask

  task automatic test_enable_drop();
    int n, busy;
    edge_poll(1'b0, 1'b0, 1'b1);
    tests++;
    if (!(obs_cs[3] && obs_wn[3] && obs_addr[3] == 2'd0) || {event_valid, event_level, event_count} !== {1'b1, 1'b0, CW'(5)}) begin
      fails++;
      $display("FAIL drop_completes: rd0 cs=%b a=%0d v=%b l=%b cnt=%0d, required cs=1 a=0 1 0 5",
               obs_cs[3], obs_addr[3], event_valid, event_level, event_count);
    end
    busy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (avm_chipselect) busy++;
    end
    tests++;
    if (busy !== 0) begin
      fails++;
      $display("FAIL disabled_idle: got %0d bus cycles, required 0", busy);
    end
    enable = 1'b1;
    wait_rd3(n);
    tests++;
    if (n !== P) begin
      fails++;
      $display("FAIL reenable_poll: got %0d cycles, required %0d", n, P);
    end
    $display("[TB] enable drop checked");
  endtask

  task automatic test_reset_mid();
    int n;
    button = 1'b1;
    inject = 1'b1;
    @(negedge clk);
    inject = 1'b0;
    wait_rd3(n);
    repeat (3) @(negedge clk);
    tests++;
    if (!(avm_chipselect && avm_write_n && avm_address == 2'd0)) begin
      fails++;
      $display("FAIL reach_rd_data: cs=%b wn=%b a=%0d, required 1 1 0", avm_chipselect, avm_write_n, avm_address);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({avm_chipselect, avm_write_n, avm_address, event_valid, event_level, event_count, overrun}
        !== {1'b0, 1'b1, 2'd0, 1'b0, 1'b0, {CW{1'b0}}, 1'b0}) begin
      fails++;
      $display("FAIL async_reset: cs=%b wn=%b a=%0d v=%b l=%b cnt=%0d ovr=%b, required 0 1 0 0 0 0 0",
               avm_chipselect, avm_write_n, avm_address, event_valid, event_level, event_count, overrun);
    end
    @(negedge clk);
    reset_n = 1'b1;
    wait_rd3(n);
    tests++;
    if (n !== P) begin
      fails++;
      $display("FAIL post_reset_poll: got %0d cycles, required %0d", n, P);
    end
    $display("[TB] mid-transaction reset checked");
  endtask

  task automatic test_wrap();
    logic lvl;
    event_ready = 1'b1;
    for (int i = 0; i < (1 << CW); i++) begin
      lvl = 1'($urandom_range(0, 1));
      edge_poll(lvl, 1'b0, 1'b0);
      tests++;
      if (event_count !== CW'((i + 1) % (1 << CW)) || event_level !== lvl || event_valid !== 1'b1) begin
        fails++;
        $display("FAIL count_wrap[%0d]: cnt=%0d l=%b v=%b, required %0d %b 1",
                 i, event_count, event_level, event_valid, (i + 1) % (1 << CW), lvl);
      end
    end
    event_ready = 1'b0;
    $display("[TB] count wrap checked");
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tests++;
      if (event_valid !== m_valid || event_count !== m_count || overrun !== m_ovr) begin
        fails++;
        $display("FAIL random_state[%0d]: v=%b cnt=%0d ovr=%b, required %b %0d %b",
                 c, event_valid, event_count, overrun, m_valid, m_count, m_ovr);
      end
      if (m_valid) begin
        tests++;
        if (event_level !== m_level) begin
          fails++;
          $display("FAIL random_level[%0d]: l=%b, required %b", c, event_level, m_level);
        end
      end
      if (avm_chipselect && !avm_write_n) begin
        tests++;
        if (avm_writedata !== 32'd0 || avm_address !== 2'd3) begin
          fails++;
          $display("FAIL random_write[%0d]: a=%0d wd=%h, required 3 0", c, avm_address, avm_writedata);
        end
      end
      event_ready = ($urandom_range(0, 3) == 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
      inject      = ($urandom_range(0, 7) == 0);
      button      = 1'($urandom_range(0, 1));
      enable      = ($urandom_range(0, 31) != 0);
    end
    inject = 1'b0;
    overrun_clr = 1'b0;
    event_ready = 1'b0;
    $display("[TB] random traffic checked, model events=%0d", m_count);
  endtask

  initial begin
    test_reset();
    test_poll_period();
    test_edge_event();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
